// File: rtl/condicionador_chaves_pkg.sv
// rtl/condicionador_chaves_pkg.sv - shared game encodings and helpers for the key conditioner
package condicionador_chaves_pkg;

  // Default number of consecutive stable cycles needed to accept a press or a release
  localparam int DEBOUNCE_CICLOS_PADRAO = 4;

  // Key-conditioner FSM states; the codes drive the 7-segment debug display
  typedef enum logic [3:0] {
    ESPERA         = 4'd0,
    FILTRA         = 4'd1,
    VALIDA         = 4'd2,
    SEGURA         = 4'd3,
    FILTRA_SOLTURA = 4'd4,
    INVALIDA       = 4'd5
  } estado_chaves_t;

  // True when exactly one key is pressed
  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Counter width able to hold limite without wrapping (at least one bit)
  function automatic int largura_para(input int limite);
    return (limite > 1) ? $clog2(limite + 1) : 1;
  endfunction

endpackage

// File: rtl/condicionador_chaves_contador_estabilidade.sv
// rtl/condicionador_chaves_contador_estabilidade.sv - saturating stability counter with terminal-count flag
module contador_estabilidade
  import condicionador_chaves_pkg::*;
#(
  parameter int FIM_CONTAGEM = DEBOUNCE_CICLOS_PADRAO - 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_fim
);

  localparam int LARGURA = largura_para(FIM_CONTAGEM);
  localparam logic [LARGURA-1:0] VALOR_FIM = LARGURA'(FIM_CONTAGEM);

  logic [LARGURA-1:0] r_contador;
  logic               w_fim;

  assign w_fim = (r_contador == VALOR_FIM);
  assign o_fim = w_fim;

  // Counts stable cycles; holds at the terminal value so it can never wrap
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_contador <= '0;
    end else if (i_enable && !w_fim) begin
      r_contador <= r_contador + LARGURA'(1);
    end
  end

endmodule

// File: rtl/condicionador_chaves.sv
// rtl/condicionador_chaves.sv - push-button synchronizer, debouncer and press validator
module condicionador_chaves
  import condicionador_chaves_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic [3:0] db_estado
);

  estado_chaves_t r_estado;
  estado_chaves_t w_prox_estado;
  logic [3:0]     r_sinc1;
  logic [3:0]     r_sinc2;
  logic [3:0]     r_candidato;
  logic [3:0]     r_jogada;
  logic           w_fim;
  logic           w_limpa;
  logic           w_incrementa;
  logic           w_carrega_candidato;
  logic           w_carrega_jogada;

  // Two-flop synchronizer; everything downstream looks only at r_sinc2
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sinc1 <= 4'b0000;
      r_sinc2 <= 4'b0000;
    end else begin
      r_sinc1 <= chaves;
      r_sinc2 <= r_sinc1;
    end
  end

  // One shared counter times both the press filter and the release filter
  contador_estabilidade #(
    .FIM_CONTAGEM (DEBOUNCE_CICLOS - 1)
  ) u_contador (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (w_limpa),
    .i_enable (w_incrementa),
    .o_fim    (w_fim)
  );

  // State register; reset wins over any transition
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ESPERA;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_prox_estado       = r_estado;
    w_limpa             = 1'b0;
    w_incrementa        = 1'b0;
    w_carrega_candidato = 1'b0;
    w_carrega_jogada    = 1'b0;
    case (r_estado)
      ESPERA: begin
        if (habilita && (r_sinc2 != 4'b0000)) begin
          w_prox_estado       = FILTRA;
          w_carrega_candidato = 1'b1;
          w_limpa             = 1'b1;
        end
      end
      FILTRA: begin
        if (r_sinc2 != r_candidato) begin
          w_prox_estado = ESPERA;
          w_limpa       = 1'b1;
        end else if (w_fim) begin
          if (eh_one_hot(r_candidato)) begin
            w_prox_estado    = VALIDA;
            w_carrega_jogada = 1'b1;
          end else begin
            w_prox_estado = INVALIDA;
          end
        end else begin
          w_incrementa = 1'b1;
        end
      end
      VALIDA, INVALIDA: begin
        w_prox_estado = SEGURA;
      end
      SEGURA: begin
        if (r_sinc2 == 4'b0000) begin
          w_prox_estado = FILTRA_SOLTURA;
          w_limpa       = 1'b1;
        end
      end
      FILTRA_SOLTURA: begin
        if (r_sinc2 != 4'b0000) begin
          w_prox_estado = SEGURA;
        end else if (w_fim) begin
          w_prox_estado = ESPERA;
        end else begin
          w_incrementa = 1'b1;
        end
      end
      default: begin
        w_prox_estado = ESPERA;
      end
    endcase
  end

  // Candidate press captured when filtering starts
  always_ff @(posedge clock) begin
    if (reset) begin
      r_candidato <= 4'b0000;
    end else if (w_carrega_candidato) begin
      r_candidato <= r_sinc2;
    end
  end

  // Accepted press code; updated only on entry to VALIDA
  always_ff @(posedge clock) begin
    if (reset) begin
      r_jogada <= 4'b0000;
    end else if (w_carrega_jogada) begin
      r_jogada <= r_candidato;
    end
  end

  assign jogada          = r_jogada;
  assign jogada_feita    = (r_estado == VALIDA);
  assign jogada_invalida = (r_estado == INVALIDA);
  assign db_estado       = r_estado;

endmodule

// File: doc/condicionador_chaves.md
CONDICIONADOR_CHAVES -- requirements
Module: condicionador_chaves

Interface
REQ-001 Parameter: DEBOUNCE_CICLOS, default 4, number of consecutive stable cycles needed to accept a press or a release.
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 chaves  input  4  raw, asynchronous push-button levels; 1 = pressed.
REQ-005 habilita  input  1  when 1, a new press may be accepted.
REQ-006 jogada  output  4  registered code of the last accepted one-hot press.
REQ-007 jogada_feita  output  1  one-cycle pulse marking acceptance of a valid press.
REQ-008 jogada_invalida  output  1  one-cycle pulse marking a debounced press with more than one bit set.
REQ-009 db_estado  output  4  current FSM state code, for the 7-segment display.

Function
REQ-010 chaves SHALL pass through a 2-flop synchronizer; all other logic SHALL use only the synchronized value (s2).
REQ-011 The FSM SHALL have these states and codes: ESPERA=0, FILTRA=1, VALIDA=2, SEGURA=3, FILTRA_SOLTURA=4, INVALIDA=5.
REQ-012 ESPERA: if habilita=1 and s2≠0, go to FILTRA, latch candidato=s2, clear contador. Otherwise stay.
REQ-013 FILTRA, s2≠candidato: return to ESPERA and clear contador.
REQ-014 FILTRA, s2=candidato and contador<DEBOUNCE_CICLOS-1: increment contador.
REQ-015 FILTRA, s2=candidato and contador=DEBOUNCE_CICLOS-1: if candidato is one-hot, go to VALIDA and load jogada=candidato; otherwise go to INVALIDA.
REQ-016 VALIDA and INVALIDA SHALL last exactly one cycle and then go to SEGURA.
REQ-017 jogada_feita=1 only in VALIDA; jogada_invalida=1 only in INVALIDA. Both are Moore outputs.
REQ-018 SEGURA: on s2=0, go to FILTRA_SOLTURA and clear contador. Otherwise stay.
REQ-019 FILTRA_SOLTURA: on s2≠0, return to SEGURA. After DEBOUNCE_CICLOS consecutive zero cycles, go to ESPERA.
REQ-020 Latency: if chaves changes before rising edge k and stays stable, jogada_feita SHALL be high in the cycle after edge k+DEBOUNCE_CICLOS+2.
REQ-021 A held key SHALL generate exactly one pulse; a new pulse requires a debounced release first.
REQ-022 jogada SHALL change only on entry to VALIDA. It holds its value through INVALIDA, release, and habilita=0.
REQ-023 habilita=0 SHALL block only the ESPERA→FILTRA transition; an in-progress filter or release completes normally.
REQ-024 contador SHALL be wide enough for DEBOUNCE_CICLOS-1 and SHALL never wrap.
REQ-025 A glitch shorter than DEBOUNCE_CICLOS cycles SHALL produce no pulse and no jogada change.

Reset
REQ-026 On reset=1 at a rising edge, the block SHALL set: state=ESPERA, synchronizer flops=0, candidato=0, contador=0, jogada=0000, jogada_feita=0, jogada_invalida=0, db_estado=0.
REQ-027 Reset SHALL take priority over every transition, including mid-FILTRA and during VALIDA.
REQ-028 After reset, a key still held SHALL be treated as a new press.

Structure
REQ-029 State codes and the default DEBOUNCE_CICLOS SHALL live in the shared game package, alongside the other FSM encodings.
REQ-030 The stability counter SHALL be one sub-module, contador_estabilidade, with clear, enable and fim (terminal count) ports. It is used by both FILTRA and FILTRA_SOLTURA.
REQ-031 The FSM, synchronizer and jogada register SHALL stay in the top module.
REQ-032 db_estado SHALL feed the existing hexa7seg decoder, outside this block.

Verification (DEBOUNCE_CICLOS=4, 20 ns clock)
REQ-033 Reset pulse, then chaves=0000 for 5 cycles -> db_estado=0, jogada=0000, no pulses.
REQ-034 habilita=1, chaves=0100 from a negedge, held 12 cycles -> exactly one jogada_feita pulse, in the cycle after the 7th rising edge; jogada=0100 afterwards.
REQ-035 chaves=0010 for 2 cycles, then 0000 -> no pulse, db_estado returns to 0, jogada unchanged.
REQ-036 chaves=0110 held 8 cycles -> one jogada_invalida pulse, no jogada_feita, jogada unchanged, db_estado=3 while held.
REQ-037 Press 1000 with release bounces (0/1000 alternating for 3 cycles, then 0 for 6) -> one jogada_feita only; return to ESPERA after 4 stable zero cycles.
REQ-038 Reset asserted mid-FILTRA (contador=2) with chaves=0001 held -> after reset, a fresh full filter, and jogada_feita 6 cycles after reset release.
